// File: rtl/pipe_arbiter_pkg.sv
// Shared types for the arbitrated 3-stage arithmetic pipeline: defaults, tag record, FSM encodings.
// Tag id is sized for the largest supported requester count (8).
package pipe_arbiter_pkg;

  localparam int N_DEF   = 20;
  localparam int LAT_DEF = 3;
  localparam int IDW     = 3;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a registered pointer.
// Zero latency grant; the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] ptr;

  always_comb begin : search
    int            j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (en && !gnt_vld && req[jj]) begin
        gnt_vld  = 1'b1;
        gnt[jj]  = 1'b1;
        gnt_idx  = jj;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one fixed-latency, non-stalling arithmetic pipeline between NREQ requesters.
// Result returns LAT edges after issue as a one-hot rsp pulse; halt stops issue and drains.
module pipe_arbiter
  import pipe_arbiter_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = 4,
  parameter  int LAT  = LAT_DEF,
  localparam int TW   = $clog2(NREQ),
  localparam int CW   = $clog2(LAT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  input  logic [NREQ*N-1:0] req_d,
  input  logic            halt,
  output logic [N-1:0]    pipe_a,
  output logic [N-1:0]    pipe_b,
  output logic [N-1:0]    pipe_c,
  output logic [N-1:0]    pipe_d,
  input  logic [N-1:0]    pipe_f,
  output logic [NREQ-1:0] rsp_valid,
  output logic [N-1:0]    rsp_data,
  output logic [CW-1:0]   inflight,
  output logic            halted
);

  logic [1:0]      state, state_nxt;
  tag_t            tag_q [LAT];
  tag_t            tag_in;
  logic [NREQ-1:0] gnt;
  logic [TW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            issue_en;
  logic            any_tag;
  logic [CW-1:0]   cnt_nxt;

  // Halt is checked combinationally so the cycle it rises never issues.
  assign issue_en  = rst_n && (state == ST_RUN) && !halt;
  assign req_ready = gnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (issue_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    tag_in.vld = gnt_vld;
    tag_in.id  = IDW'(gnt_idx);
  end

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k < LAT; k++) any_tag = any_tag | tag_q[k].vld;
  end

  // Occupancy after this edge: the new slot plus everything not retiring.
  always_comb begin
    cnt_nxt = CW'(gnt_vld);
    for (int k = 0; k < LAT - 1; k++) cnt_nxt = cnt_nxt + CW'(tag_q[k].vld);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (halt) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!halt) state_nxt = ST_RUN;
                 else if (!any_tag) state_nxt = ST_HALTED;
      ST_HALTED: if (!halt) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      halted    <= 1'b0;
      pipe_a    <= '0;
      pipe_b    <= '0;
      pipe_c    <= '0;
      pipe_d    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      state    <= state_nxt;
      halted   <= (state_nxt == ST_HALTED);
      inflight <= cnt_nxt;
      if (gnt_vld) begin
        pipe_a <= req_a[gnt_idx*N +: N];
        pipe_b <= req_b[gnt_idx*N +: N];
        pipe_c <= req_c[gnt_idx*N +: N];
        pipe_d <= req_d[gnt_idx*N +: N];
      end
      // The pipeline never stalls, so the tag line shifts every cycle.
      tag_q[0] <= tag_in;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_q[LAT-1].vld) begin
        rsp_data  <= pipe_f;
        rsp_valid <= NREQ'(1) << tag_q[LAT-1].id;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with a behavioural 3-stage pipeline and a response scoreboard.
module tb_pipe_arbiter;

  localparam int N    = 20;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [N-1:0]    f;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b, req_c, req_d;
  logic              halt;
  logic [N-1:0]      pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic [1:0]        inflight;
  logic              halted;

  logic [N-1:0] opa [NREQ];
  logic [N-1:0] opb [NREQ];
  logic [N-1:0] opc [NREQ];
  logic [N-1:0] opd [NREQ];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .halt      (halt),
    .pipe_a    (pipe_a),
    .pipe_b    (pipe_b),
    .pipe_c    (pipe_c),
    .pipe_d    (pipe_d),
    .pipe_f    (pipe_f),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .inflight  (inflight),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] fm(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] s;
    s  = a + b;
    fm = s * c - d;
  endfunction

  // Behavioural pipeline: operand registers in the DUT plus two stages here.
  logic [4*N-1:0] st1, st2;
  always @(posedge clk) begin
    st1 <= {pipe_a, pipe_b, pipe_c, pipe_d};
    st2 <= st1;
  end
  assign pipe_f = fm(st2[4*N-1:3*N], st2[3*N-1:2*N], st2[2*N-1:N], st2[N-1:0]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && rsp_valid !== '0) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL stray_rsp observed=%0h expected=none", rsp_valid);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_valid_sb", 64'(rsp_valid), 64'(e.v));
        chk("rsp_data_sb", 64'(rsp_data), 64'(e.f));
      end
    end
  end

  task automatic newops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = N'($urandom_range(0, 1000));
      opb[i] = N'($urandom_range(0, 1000));
      opc[i] = N'($urandom_range(0, 50));
      opd[i] = N'($urandom_range(0, 100));
    end
  endtask

  // One cycle: drive at the falling edge, check the grant, record the expected response.
  task automatic drive(input logic [NREQ-1:0] v, input logic h, input logic [NREQ-1:0] exp_g,
                       input bit fresh, input string tag);
    exp_t e;
    @(negedge clk);
    if (fresh) newops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = opa[i];
      req_b[i*N +: N] = opb[i];
      req_c[i*N +: N] = opc[i];
      req_d[i*N +: N] = opd[i];
    end
    req_valid = v;
    halt      = h;
    #1;
    chk(tag, 64'(req_ready), 64'(exp_g));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_g[i]) begin
        e.v = exp_g;
        e.f = fm(opa[i], opb[i], opc[i], opd[i]);
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    halt      = 1'b0;
    req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    newops();

    // Reset holds everything at zero even with all requesters valid.
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_pipe_a", 64'(pipe_a), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;

    // Single request from requester 2.
    newops();
    opa[2] = 20'd10; opb[2] = 20'd12; opc[2] = 20'd6; opd[2] = 20'd3;
    drive(4'b0100, 1'b0, 4'b0100, 1'b0, "single_grant");
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 1'b0, 4'b0000, 1'b1, "single_idle");
      if (k == 0) chk("single_pipe_a", 64'(pipe_a), 64'd10);
      chk("single_rsp_timing", 64'(rsp_valid), (k == 3) ? 64'h4 : 64'h0);
      chk("single_inflight", 64'(inflight), (k < 3) ? 64'd1 : 64'd0);
      if (k == 3) chk("single_rsp_data", 64'(rsp_data), 64'd129);
    end

    // Sparse with wrap: pointer sits at 3, only 1 and 3 request.
    drive(4'b1010, 1'b0, 4'b1000, 1'b1, "sparse_g3");
    drive(4'b1010, 1'b0, 4'b0010, 1'b1, "sparse_g1");
    drive(4'b1000, 1'b0, 4'b1000, 1'b1, "align_g3");
    repeat (4) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "gap");

    // Fairness: strict rotation from requester 0, occupancy saturates at LAT.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b0, 4'(1 << (k % 4)), 1'b1, "fair_grant");
      chk("fair_inflight", 64'(inflight), (k < 3) ? 64'(k) : 64'd3);
    end
    drive(4'b0001, 1'b0, 4'b0001, 1'b1, "pre_halt_g0");
    chk("pre_halt_inflight", 64'(inflight), 64'd3);

    // Halt with three in flight: no grants, drain, then halted.
    for (int h = 0; h < 5; h++) begin
      drive(4'b1111, 1'b1, 4'b0000, 1'b1, "halt_no_grant");
      chk("halt_inflight", 64'(inflight), (h < 3) ? 64'(3 - h) : 64'd0);
      chk("halt_halted", 64'(halted), (h == 4) ? 64'd1 : 64'd0);
    end
    chk("halt_drained", 64'(sb.size()), 64'd0);

    // Release: one cycle leaving HALTED, then resume from the saved pointer (1).
    drive(4'b1111, 1'b0, 4'b0000, 1'b1, "resume_wait");
    chk("resume_halted_hi", 64'(halted), 64'd1);
    drive(4'b1111, 1'b0, 4'b0010, 1'b1, "resume_g1");
    chk("resume_halted_lo", 64'(halted), 64'd0);
    drive(4'b1111, 1'b0, 4'b0100, 1'b1, "resume_g2");

    // Asynchronous reset with two results still in the pipeline.
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("midrst_inflight_pre", 64'(inflight), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_inflight", 64'(inflight), 64'd0);
    chk("midrst_pipe_a", 64'(pipe_a), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(4'b0000, 1'b0, 4'b0000, 1'b1, "post_rst_idle");
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Fresh work after reset starts from pointer 0 and still completes.
    drive(4'b0010, 1'b0, 4'b0010, 1'b1, "post_rst_g1");
    repeat (5) drive(4'b0000, 1'b0, 4'b0000, 1'b1, "final_idle");
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
